// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the alu_pipe slice:
//   ALU_CODE_W   width of the operation select
//   OP_*         operation codes accepted on alu_code
//   alu_state_e  control states of alu_pipe (IDLE, MUL, HOLD)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CODE_W = 4;

  localparam logic [ALU_CODE_W-1:0] OP_AND  = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] OP_OR   = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] OP_SLT  = 4'b0101;
  localparam logic [ALU_CODE_W-1:0] OP_SLTU = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] OP_SLL  = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] OP_SRL  = 4'b1000;
  localparam logic [ALU_CODE_W-1:0] OP_SRA  = 4'b1001;
  localparam logic [ALU_CODE_W-1:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if
// Issue/result bundle between the EX-stage issue logic and alu_pipe.
//   flush                          kill in-flight operation and held result
//   in_valid/in_ready              operation handshake
//   alu_code, rs1, rs2, in_tag     operation payload
//   out_valid/out_ready            result handshake
//   result, out_tag, overflow,
//   zero, illegal                  result payload
// Modports: master = issuer/consumer side, slave = the ALU.
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);

  logic                           flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [alu_pkg::ALU_CODE_W-1:0] alu_code;
  logic [XLEN-1:0]                rs1;
  logic [XLEN-1:0]                rs2;
  logic [TAG_W-1:0]               in_tag;
  logic                           out_valid;
  logic                           out_ready;
  logic [XLEN-1:0]                result;
  logic [TAG_W-1:0]               out_tag;
  logic                           overflow;
  logic                           zero;
  logic                           illegal;

  modport master (
    output flush, in_valid, alu_code, rs1, rs2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, overflow, zero, illegal
  );

  modport slave (
    input  flush, in_valid, alu_code, rs1, rs2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, overflow, zero, illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Radix-2 shift-add multiplier producing the low XLEN bits of a*b, one
// multiplier bit per clock.
//   clk, rst   clock, asynchronous active-high reset
//   kill       synchronous abort of a running multiply
//   start      load a/b, clear accumulator and counter
//   a, b       operands (signedness irrelevant for the low half)
//   done       high in the cycle of the final iteration
//   product    final product, valid while done is high
// -----------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  mcand_reg;
  logic [XLEN-1:0]  mplier_reg;
  logic [XLEN-1:0]  acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic [XLEN-1:0]  acc_next;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  // The last iteration's sum is handed out directly so the owner can
  // register it on the same edge the iteration would have completed.
  assign done    = busy_reg && (cnt_reg == CNT_W'(XLEN - 1));
  assign product = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (kill) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= {mcand_reg[XLEN-2:0], 1'b0};
      mplier_reg <= {1'b0, mplier_reg[XLEN-1:1]};
      cnt_reg    <= cnt_reg + 1'b1;
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered EX-stage ALU with valid/ready handshake and pass-through tag.
// Single-cycle ops: AND OR ADD SUB XOR SLT SLTU SLL SRL SRA.
// Optional iterative MUL, built only when ALU_PIPE_MUL_EN is defined;
// otherwise code 1010 is reported illegal with single-cycle latency.
// Ports:
//   clk   single clock
//   rst   asynchronous active-high reset
//   bus   alu_pipe_if.slave (flush, issue handshake/payload, result
//         handshake/payload)
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);

  alu_state_e       state_reg;
  alu_state_e       state_next;
  logic [XLEN-1:0]  result_reg;
  logic [TAG_W-1:0] out_tag_reg;
  logic             overflow_reg;
  logic             zero_reg;
  logic             illegal_reg;

  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             mul_done;
  logic [XLEN-1:0]  mul_product;

  logic [XLEN-1:0]    sum;
  logic [XLEN-1:0]    diff;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    op_result;
  logic               op_overflow;
  logic               op_illegal;

  // Without the multiplier the MUL state is unreachable, so this is the
  // same as !flush && (!out_valid || out_ready).
  assign in_ready = !rst && !bus.flush &&
                    ((state_reg == IDLE) || ((state_reg == HOLD) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
  assign is_mul = (bus.alu_code == OP_MUL);

  alu_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .kill    (bus.flush),
    .start   (accept && is_mul),
    .a       (bus.rs1),
    .b       (bus.rs2),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle operation decode; MUL and unknown codes land in default.
  assign sum   = bus.rs1 + bus.rs2;
  assign diff  = bus.rs1 - bus.rs2;
  assign shamt = bus.rs2[SHAMT_W-1:0];

  always_comb begin
    op_result   = '0;
    op_overflow = 1'b0;
    op_illegal  = 1'b0;
    case (bus.alu_code)
      OP_AND:  op_result = bus.rs1 & bus.rs2;
      OP_OR:   op_result = bus.rs1 | bus.rs2;
      OP_XOR:  op_result = bus.rs1 ^ bus.rs2;
      OP_ADD: begin
        op_result   = sum;
        op_overflow = (bus.rs1[XLEN-1] == bus.rs2[XLEN-1]) &&
                      (sum[XLEN-1] != bus.rs1[XLEN-1]);
      end
      OP_SUB: begin
        op_result   = diff;
        op_overflow = (bus.rs1[XLEN-1] != bus.rs2[XLEN-1]) &&
                      (diff[XLEN-1] != bus.rs1[XLEN-1]);
      end
      OP_SLT:  op_result = {{(XLEN-1){1'b0}}, ($signed(bus.rs1) < $signed(bus.rs2))};
      OP_SLTU: op_result = {{(XLEN-1){1'b0}}, (bus.rs1 < bus.rs2)};
      OP_SLL:  op_result = bus.rs1 << shamt;
      OP_SRL:  op_result = bus.rs1 >> shamt;
      OP_SRA:  op_result = $signed(bus.rs1) >>> shamt;
      default: op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: if (accept) state_next = is_mul ? MUL : HOLD;
        MUL:  if (mul_done) state_next = HOLD;
        HOLD: begin
          // A new accept in HOLD implies out_ready, i.e. back-to-back.
          if (accept)             state_next = is_mul ? MUL : HOLD;
          else if (bus.out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      result_reg   <= '0;
      out_tag_reg  <= '0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b1;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        out_tag_reg <= bus.in_tag;
        if (!is_mul) begin
          result_reg   <= op_result;
          overflow_reg <= op_overflow;
          zero_reg     <= (op_result == '0);
          illegal_reg  <= op_illegal;
        end
      end else if ((state_reg == MUL) && mul_done && !bus.flush) begin
        result_reg   <= mul_product;
        overflow_reg <= 1'b0;
        zero_reg     <= (mul_product == '0);
        illegal_reg  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.result    = result_reg;
  assign bus.out_tag   = out_tag_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.zero      = zero_reg;
  assign bus.illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe at XLEN=64, TAG_W=5. Table of vectors
// issued back-to-back into a scoreboard, then hand-written sequences for
// MUL latency, stall/flush and reset during an operation. Honors
// ALU_PIPE_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  localparam int NVEC  = 16;

  typedef struct {
    logic [3:0]       code;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp_res;
    logic             exp_ovf;
    logic             exp_ill;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic             ovf;
    logic             ill;
    logic [TAG_W-1:0] tag;
    int               exp_cyc;
    bit               chk_lat;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[NVEC];

  alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h required 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: pops when a result is actually taken by the consumer.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got result 0x%h tag %0d, required none", bus.result, bus.out_tag);
      end else begin
        mon_e = sb_q.pop_front();
        $display("tx tag=%0d result=0x%h ovf=%b zero=%b illegal=%b cycle=%0d",
                 bus.out_tag, bus.result, bus.overflow, bus.zero, bus.illegal, cyc);
        check("result",   bus.result, mon_e.res);
        check("overflow", 64'(bus.overflow), 64'(mon_e.ovf));
        check("zero",     64'(bus.zero), 64'(mon_e.res == '0));
        check("illegal",  64'(bus.illegal), 64'(mon_e.ill));
        check("out_tag",  64'(bus.out_tag), 64'(mon_e.tag));
        if (mon_e.chk_lat) check("latency_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
      end
    end
  end

  // Offer one operation; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] code, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] er, input logic eo,
                      input logic ei, input bit push, input int lat, output int waited);
    bit acc;
    acc    = 1'b0;
    waited = 0;
    bus.alu_code = code;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    while (!acc && waited < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        if (push) sb_q.push_back('{res: er, ovf: eo, ill: ei, tag: tag,
                                   exp_cyc: cyc + lat, chk_lat: bus.out_ready});
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int lat;
    int low_cnt;
    logic [3:0] rcode;

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_code  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'd1, 64'h8000_0000_0000_0000, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB,  64'd5, 64'd5, 5'd2, 64'd0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SLT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 64'd1, 1'b0, 1'b0};
    vecs[3]  = '{OP_SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'd0, 1'b0, 1'b0};
    vecs[4]  = '{OP_SRA,  64'h8000_0000_0000_0000, 64'h43, 5'd5, 64'hF000_0000_0000_0000, 1'b0, 1'b0};
    vecs[5]  = '{OP_AND,  64'hF0F0, 64'hFF00, 5'd6, 64'hF000, 1'b0, 1'b0};
    vecs[6]  = '{OP_OR,   64'hF0F0, 64'h0F0F, 5'd7, 64'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{OP_XOR,  64'hFF00, 64'h0FF0, 5'd8, 64'hF0F0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SLL,  64'h3, 64'h7C, 5'd9, 64'h3000_0000_0000_0000, 1'b0, 1'b0};
    vecs[9]  = '{OP_SRL,  64'h8000_0000_0000_0000, 64'h3F, 5'd10, 64'h1, 1'b0, 1'b0};
    vecs[10] = '{OP_SUB,  64'h8000_0000_0000_0000, 64'h1, 5'd11, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[11] = '{OP_ADD,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd12, 64'd0, 1'b0, 1'b0};
    vecs[12] = '{OP_ADD,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd13, 64'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b1111, 64'h1234, 64'h5678, 5'd14, 64'd0, 1'b0, 1'b1};
    vecs[14] = '{OP_SLT,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd0, 1'b0, 1'b0};
`ifdef ALU_PIPE_MUL_EN
    vecs[15] = '{OP_MUL,  64'd6, 64'd7, 5'd16, 64'd42, 1'b0, 1'b0};
`else
    vecs[15] = '{OP_MUL,  64'd6, 64'd7, 5'd16, 64'd0, 1'b0, 1'b1};
`endif

    // Reset state, sampled while rst is still asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result",    bus.result, 64'd0);
    check("rst_out_tag",   64'(bus.out_tag), 64'd0);
    check("rst_overflow",  64'(bus.overflow), 64'd0);
    check("rst_zero",      64'(bus.zero), 64'd1);
    check("rst_illegal",   64'(bus.illegal), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Table: back-to-back issue with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      lat = 1;
`ifdef ALU_PIPE_MUL_EN
      if (vecs[i].code == OP_MUL) lat = XLEN;
`endif
      send(vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp_res,
           vecs[i].exp_ovf, vecs[i].exp_ill, 1'b1, lat, waited);
      check("issue_wait", 64'(waited), 64'd1);
    end
    drain();

`ifdef ALU_PIPE_MUL_EN
    // MUL: in_ready low for XLEN cycles, result XLEN cycles after accept.
    send(OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD,
         1'b0, 1'b0, 1'b1, XLEN, waited);
    low_cnt = 0;
    for (int i = 0; i < XLEN; i++) begin
      @(negedge clk);
      if (!bus.in_ready) low_cnt++;
      @(posedge clk);
      #1;
    end
    check("mul_in_ready_low_cycles", 64'(low_cnt), 64'(XLEN));
    @(negedge clk);
    check("mul_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
    drain();
`endif

    // Stall with out_ready low, then flush on the 3rd cycle.
    bus.out_ready = 1'b0;
    send(OP_ADD, 64'd2, 64'd3, 5'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1, waited);
    for (int c = 1; c <= 4; c++) begin
      if (c == 3) bus.flush = 1'b1;
      @(negedge clk);
      if (c <= 3) begin
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_result",    bus.result, 64'd5);
        check("stall_out_tag",   64'(bus.out_tag), 64'd3);
        check("stall_zero",      64'(bus.zero), 64'd0);
        check("stall_in_ready",  64'(bus.in_ready), 64'd0);
      end else begin
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready",  64'(bus.in_ready), 64'd1);
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
    end

    // Reset in the middle of an operation.
`ifdef ALU_PIPE_MUL_EN
    bus.out_ready = 1'b1;
    rcode = OP_MUL;
`else
    rcode = OP_ADD;
`endif
    send(rcode, 64'd5, 64'd5, 5'd9, 64'd0, 1'b0, 1'b0, 1'b0, 1, waited);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  64'(bus.in_ready), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_result",    bus.result, 64'd0);
    check("midrst_out_tag",   64'(bus.out_tag), 64'd0);
    check("midrst_overflow",  64'(bus.overflow), 64'd0);
    check("midrst_zero",      64'(bus.zero), 64'd1);
    check("midrst_illegal",   64'(bus.illegal), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < XLEN + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid) low_cnt++;
    end
    check("postrst_no_result", 64'(low_cnt), 64'd0);
    check("postrst_in_ready",  64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Normal operation after the abort.
    send(OP_ADD, 64'd1, 64'd1, 5'd30, 64'd2, 1'b0, 1'b0, 1'b1, 1, waited);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered successor to the pipelined core's combinational ALU.
- Datapath width is generic, and the operation set adds XOR, compares and shifts.
- An iterative multiplier is optional, and a destination tag travels with each operation.
- Sits in the EX stage behind a valid/ready handshake, so multi-cycle operations stall issue without extra hazard logic.

## Interface
- `XLEN`, 64, operand/result width; power of two, ≥ 8.
- `TAG_W`, 5, width of the pass-through tag (destination register index).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous kill of the in-flight operation and any held result.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: the block can accept an operation this cycle.
- `alu_code` in 4: operation select.
- `rs1`, `rs2` in XLEN: operands, two's complement.
- `in_tag` in TAG_W: tag carried to the output.
- `out_valid` out 1: the result registers hold a valid result.
- `out_ready` in 1: the consumer takes the result.
- `result` out XLEN: the result.
- `out_tag` out TAG_W: tag of the accepted operation.
- `overflow` out 1: signed overflow flag, ADD/SUB only.
- `zero` out 1: set when `result` equals 0.
- `illegal` out 1: the operation code was unsupported.

## Operation
- Codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU (unsigned).
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL (low XLEN bits of the product).
- All other codes are illegal: result 0, `zero`=1, `overflow`=0, `illegal`=1.
- Compare results are zero-extended to XLEN (0 or 1).
- Shift amount is `rs2[log2(XLEN)-1:0]`; upper bits of `rs2` are ignored.
- `overflow`:
  - ADD: operand sign bits equal and result sign differs from `rs1`.
  - SUB: operand sign bits differ and result sign differs from `rs1`.
  - All other operations: 0.
- Arithmetic wraps modulo 2^XLEN.
- State machine states are IDLE, MUL and HOLD:
  - IDLE to HOLD: accept of a single-cycle operation; the result is registered on the accept edge.
  - IDLE to MUL: accept of MUL. Operands are latched and the iteration counter is cleared.
  - MUL to HOLD: the counter reaches XLEN-1. The product is registered.
  - HOLD to IDLE: `out_ready` is high and no new operation is accepted that cycle.
  - HOLD to HOLD or MUL: a new operation is accepted in the same cycle the held result is taken (back-to-back).
- `in_ready` = !`flush` && (IDLE || (HOLD && `out_ready`)).
- Accept occurs when `in_valid` && `in_ready`.
- `flush` from any state: next state IDLE, `out_valid` cleared, no accept that cycle.
- The multiplier is radix-2 shift-add, one multiplier bit per cycle. Signedness is irrelevant for the low half.

## Timing
- Reset values: `out_valid`=0, `result`=0, `out_tag`=0, `overflow`=0, `zero`=1, `illegal`=0, state IDLE, counter 0.
- `in_ready` follows the formula in Operation and is 0 while `rst` is asserted.
- Single-cycle operation accepted at edge T: `out_valid` is 1 after edge T.
- MUL accepted at edge T: iterations at edges T+1..T+XLEN, and `out_valid` is 1 after edge T+XLEN. `in_ready` is 0 throughout.
- With `out_ready` low in HOLD, all outputs stay stable and `in_ready`=0.
- Throughput for single-cycle operations with `out_ready` tied high: one per cycle.
- `rst` asserted during MUL aborts it immediately; the partial product is discarded.

## Configuration
- `ALU_PIPE_MUL_EN` defined: MUL (1010) is implemented as described.
- Macro not defined: the multiplier and MUL state are not built. 1010 is treated as illegal with single-cycle latency, and `in_ready` reduces to !`flush` && (!`out_valid` || `out_ready`).

## Structure
- Shared package `alu_pkg` holds:
  - the opcode localparams;
  - `ALU_CODE_W`=4;
  - the state encoding (IDLE, MUL, HOLD).
- Sub-module `alu_mul_iter` holds the shift-add multiplier with start/done, instantiated only under `ALU_PIPE_MUL_EN`.
- The combinational op decode stays in the top level.

## Test plan
- XLEN=64, ADD 0x7FFF_FFFF_FFFF_FFFF + 1, `out_ready`=1 -> next cycle `result`=0x8000_0000_0000_0000, `overflow`=1, `zero`=0.
- SUB 5−5 then SLT −1 vs 1 back-to-back -> consecutive cycles: `result`=0 with `zero`=1, then `result`=1. SLTU on the same operands -> 0.
- SRA 0x8000_0000_0000_0000 by `rs2`=0x43 (shift 3) -> `result`=0xF000_0000_0000_0000.
- MUL 0xFFFF_FFFF_FFFF_FFFF × 3, tag 7 -> `in_ready` low for 64 cycles, `out_valid` 64 cycles after accept, `result`=0xFFFF_FFFF_FFFF_FFFD, `out_tag`=7.
- Stall and flush sequence:
  - ADD with `out_ready`=0 for 4 cycles -> outputs stable and `in_ready`=0.
  - `flush` on the 3rd cycle -> `out_valid` drops next cycle.
  - MUL interrupted by `rst` at iteration 10 -> state IDLE, all outputs at reset values.
- `alu_code`=1111 -> `illegal`=1, `result`=0, `zero`=1. Rerun code 1010 without `ALU_PIPE_MUL_EN` -> `illegal`=1 after one cycle.
